// File: rtl/tm_upravljac_if.sv
// Tape RAM and transition ROM bus between the tm_upravljac sequencer (master) and the memories (slave).
interface tm_upravljac_if #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int STATE_W = 4
);
  // Fixed-latency bus with no valid/ready: tape_q follows tape_adresa by one clock, tr_q follows
  // tr_adresa by one clock, and a write happens on every edge where tape_wren=1.
  logic [ADDR_W-1:0]          tape_adresa;
  logic [DATA_W-1:0]          tape_d;
  logic                       tape_wren;
  logic [DATA_W-1:0]          tape_q;
  logic [STATE_W+DATA_W-1:0]  tr_adresa;
  logic [STATE_W+DATA_W+1:0]  tr_q;

  modport master (
    output tape_adresa, tape_d, tape_wren, tr_adresa,
    input  tape_q, tr_q
  );

  modport slave (
    input  tape_adresa, tape_d, tape_wren, tr_adresa,
    output tape_q, tr_q
  );
endinterface

// File: rtl/tm_upravljac.sv
// Turing-machine sequencer: loader passthrough when idle, read/lookup/write/move loop when running.
// Optional single-step mode (korak input, PAUZA state) is enabled with macro TM_KORAK_EN.
module tm_upravljac #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int STATE_W   = 4,
  parameter int STEP_W    = 12,
  parameter int MAX_STEPS = 4095
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_adresa,
  input  logic [ADDR_W-1:0]   ld_adresa,
  input  logic [DATA_W-1:0]   ld_d,
  input  logic                ld_wren,
`ifdef TM_KORAK_EN
  input  logic                korak,
`endif
  tm_upravljac_if.master      bus,
  output logic [STATE_W-1:0]  stanje,
  output logic [ADDR_W-1:0]   glava,
  output logic [STEP_W-1:0]   koraci,
  output logic                zauzet,
  output logic                gotovo,
  output logic                greska,
  output logic [2:0]          fsm_dbg_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    TR    = 3'd2,
    DEC   = 3'd3,
`ifdef TM_KORAK_EN
    PAUZA = 3'd5,
`endif
    WR    = 3'd4
  } fsm_e;

  fsm_e                       fsm_q;
  logic [STATE_W-1:0]         stanje_q;
  logic [ADDR_W-1:0]          glava_q;
  logic [STEP_W-1:0]          koraci_q;
  logic                       zauzet_q;
  logic                       gotovo_q;
  logic                       greska_q;
  logic [STATE_W+DATA_W-1:0]  tr_adresa_q;
  logic [STATE_W-1:0]         next_st_q;
  logic [DATA_W-1:0]          sym_q;
  logic                       dir_q;
  logic                       halt_q;

  logic [STEP_W-1:0]          koraci_d;
  logic [STATE_W+DATA_W-1:0]  tr_adresa_d;
  logic                       off_edge;
  logic                       at_limit;

  assign koraci_d = koraci_q + STEP_W'(1);
  assign at_limit = (koraci_d == STEP_W'(MAX_STEPS));
  // Moving past either end of the tape is an error; the head never wraps.
  assign off_edge = ((glava_q == '0) && !dir_q) || ((glava_q == '1) && dir_q);

  // The lookup address is presented during TR while tape_q is valid, then held.
  assign tr_adresa_d = (fsm_q == TR) ? {stanje_q, bus.tape_q} : tr_adresa_q;
  assign bus.tr_adresa = tr_adresa_d;

  always_comb begin
    bus.tape_adresa = ld_adresa;
    bus.tape_d      = ld_d;
    bus.tape_wren   = ld_wren;
    if (fsm_q != IDLE) begin
      bus.tape_adresa = glava_q;
      bus.tape_d      = sym_q;
      bus.tape_wren   = (fsm_q == WR);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= IDLE;
      stanje_q    <= '0;
      glava_q     <= '0;
      koraci_q    <= '0;
      zauzet_q    <= 1'b0;
      gotovo_q    <= 1'b0;
      greska_q    <= 1'b0;
      tr_adresa_q <= '0;
      next_st_q   <= '0;
      sym_q       <= '0;
      dir_q       <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            glava_q  <= start_adresa;
            stanje_q <= '0;
            koraci_q <= '0;
            gotovo_q <= 1'b0;
            greska_q <= 1'b0;
            zauzet_q <= 1'b1;
            fsm_q    <= RD;
          end
        end
        RD: fsm_q <= TR;
        TR: begin
          tr_adresa_q <= tr_adresa_d;
          fsm_q       <= DEC;
        end
        DEC: begin
          next_st_q <= bus.tr_q[STATE_W+DATA_W+1 -: STATE_W];
          sym_q     <= bus.tr_q[DATA_W+1:2];
          dir_q     <= bus.tr_q[1];
          halt_q    <= bus.tr_q[0];
          fsm_q     <= WR;
        end
        WR: begin
          stanje_q <= next_st_q;
          koraci_q <= koraci_d;
          if (halt_q) begin
            gotovo_q <= 1'b1;
            zauzet_q <= 1'b0;
            fsm_q    <= IDLE;
          end else if (off_edge) begin
            greska_q <= 1'b1;
            gotovo_q <= 1'b1;
            zauzet_q <= 1'b0;
            fsm_q    <= IDLE;
          end else begin
            glava_q <= dir_q ? (glava_q + ADDR_W'(1)) : (glava_q - ADDR_W'(1));
            if (at_limit) begin
              greska_q <= 1'b1;
              gotovo_q <= 1'b1;
              zauzet_q <= 1'b0;
              fsm_q    <= IDLE;
            end else begin
`ifdef TM_KORAK_EN
              fsm_q <= PAUZA;
`else
              fsm_q <= RD;
`endif
            end
          end
        end
`ifdef TM_KORAK_EN
        PAUZA: begin
          if (korak) fsm_q <= RD;
        end
`endif
        default: begin
          fsm_q    <= IDLE;
          zauzet_q <= 1'b0;
        end
      endcase
    end
  end

  assign stanje    = stanje_q;
  assign glava     = glava_q;
  assign koraci    = koraci_q;
  assign zauzet    = zauzet_q;
  assign gotovo    = gotovo_q;
  assign greska    = greska_q;
  assign fsm_dbg_o = fsm_q;

endmodule

// File: doc/tm_upravljac.md
Name: tm_upravljac

Overview:
Sequencer for the Turing-machine tape RAM (128 x 8, registered read, 1-cycle latency).
- When idle, it passes the byte-loader write port straight through to the tape.
- When running, it owns the tape: read symbol at head, look up transition table, write new symbol, move head, repeat until halt, tape edge or step limit.
- Sits between loader, tape RAM and transition ROM; status outputs drive display/LEDs.

Parameters:
ADDR_W, 7, tape address width (tape depth 2^ADDR_W)
DATA_W, 8, tape symbol width
STATE_W, 4, machine state width
STEP_W, 12, step counter width
MAX_STEPS, 4095, step limit; reaching it aborts with error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin execution; sampled only when zauzet=0
start_adresa  in  ADDR_W  initial head position, latched with start
ld_adresa  in  ADDR_W  loader address
ld_d  in  DATA_W  loader write data
ld_wren  in  1  loader write enable
tape_adresa  out  ADDR_W  tape RAM address
tape_d  out  DATA_W  tape RAM write data
tape_wren  out  1  tape RAM write enable
tape_q  in  DATA_W  tape RAM read data (valid 1 cycle after address)
tr_adresa  out  STATE_W+DATA_W  table index {stanje, symbol}
tr_q  in  STATE_W+DATA_W+2  table entry, valid 1 cycle after tr_adresa: [top STATE_W] next state, [DATA_W+1:2] write symbol, [1] direction (1=right), [0] halt
stanje  out  STATE_W  current machine state
glava  out  ADDR_W  current head position
koraci  out  STEP_W  completed steps
zauzet  out  1  busy
gotovo  out  1  run finished; sticky until next accepted start
greska  out  1  run aborted (edge or limit); sticky until next accepted start

Behaviour:
- Reset: FSM=IDLE; stanje=0, glava=0, koraci=0, zauzet=0, gotovo=0, greska=0, tr_adresa=0.
- Tape mux (combinational):
  - IDLE: tape_adresa/tape_d/tape_wren = ld_adresa/ld_d/ld_wren.
  - Otherwise: driven by FSM; loader inputs ignored.
- FSM states: IDLE, RD, TR, DEC, WR (fixed 4 cycles per step).
  - IDLE: start=1 -> glava<=start_adresa, stanje<=0, koraci<=0, gotovo<=0, greska<=0; go to RD.
  - RD: tape_adresa=glava, tape_wren=0.
  - TR: tape_q valid; tr_adresa<={stanje,tape_q}.
  - DEC: latch tr_q into next-state / symbol / dir / halt registers.
  - WR: tape_adresa=glava, tape_d=symbol, tape_wren=1 (exactly one cycle); stanje<=next state; koraci<=koraci+1.
- WR exit priority:
  1. halt=1 -> head not moved; gotovo<=1; IDLE.
  2. Move off tape (glava=0 & dir=0, or glava=2^ADDR_W-1 & dir=1) -> glava unchanged; greska<=1, gotovo<=1; IDLE. No wrap-around.
  3. koraci+1 = MAX_STEPS -> head moves; greska<=1, gotovo<=1; IDLE.
  4. Otherwise glava<=glava±1; RD.
- zauzet=1 in every state except IDLE.
- Symbol write in WR always occurs, even on halt or error.
- start while zauzet=1: ignored.
- Reset mid-run: next edge returns to IDLE with reset values; no further tape_wren from the FSM.
- Timing: cycle 0 = start sampled in IDLE. RD=1, TR=2, DEC=3, WR=4. Step n writes in cycle 4n. gotovo/zauzet=0 visible in cycle 4n+1.

Optional Feature:
TM_KORAK_EN: adds input korak (1 bit) and state PAUZA.
- With macro: after a non-terminating WR the FSM enters PAUZA (zauzet=1, tape_wren=0) and goes to RD on the cycle after korak=1. reset still aborts from PAUZA.
- Without macro: no korak port, no PAUZA; WR goes directly to RD.

Test Plan:
- Idle, ld_wren=1, ld_adresa=5, ld_d=0x41 -> same cycle tape_wren=1, tape_adresa=5, tape_d=0x41; later read of addr 5 returns 0x41.
- tape[10]=0x31; table{0,0x31}={next=2, sym=0x30, right, halt=1}; start at 10 -> tape_wren=1 at cycle 4 (addr 10, data 0x30); cycle 5: gotovo=1, greska=0, stanje=2, glava=10, koraci=1, zauzet=0.
- tape[20..22]=0x31, tape[23]=0x00; table{0,0x31}={0,0x31,right,0}, {0,0x00}={1,0x31,right,1}; start at 20 -> halt at cycle 16; tape[23]=0x31, glava=23, koraci=4, stanje=1.
- Head 127, entry {0,0x00} = {1,0x55,right,0} -> write 0x55 to 127; greska=1, gotovo=1, glava=127, koraci=1.
- MAX_STEPS=8, all-zero tape, {0,0x00}={0,0x00,right,0}, start 0 -> greska=1 at cycle 33, koraci=8, glava=8; a start pulse at cycle 6 has no effect.
- reset=1 in a WR cycle (cycle 8) -> cycle 9: tape_wren follows loader, zauzet=0, stanje=0, glava=0, koraci=0, gotovo=0.
